// File: rtl/axil_slave_pkg.sv
// Shared definitions for the AXI-Lite RAM slave.
// State encodings and AXI-Lite channel widths.
package axil_slave_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_WAITD = 2'd1,
        W_WAITA = 2'd2,
        W_RESP  = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_ram_array.sv
// Word RAM: one byte-enabled write port, one registered read port.
// A read and write to the same word on one edge returns the old word.
module axil_ram_array
    import axil_slave_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter bit          INIT_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] wmask;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    assign wmask = strb_mask(wstrb);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
        end
    end

    // Simulation-only: never-written words read back as zero.
    always_comb begin
        rd_word = mem[raddr];
        if (INIT_ZERO && $isunknown(rd_word)) begin
            rd_word = '0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI-Lite slave fronting a word RAM.
// Write and read channels run as independent FSMs.
module axil_ram_slave
    import axil_slave_pkg::*;
#(
    parameter int unsigned MEM_WORDS_LOG2 = 10,
    parameter bit          INIT_ZERO      = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] AWdata,
    input  logic              AWvalid,
    output logic              AWready,
    input  logic [PROT_W-1:0] AWprot,
    input  logic [DATA_W-1:0] Wdata,
    input  logic [STRB_W-1:0] Wstrb,
    input  logic              Wvalid,
    output logic              Wready,
    output logic              Bvalid,
    input  logic              Bready,
    input  logic [ADDR_W-1:0] ARdata,
    input  logic              ARvalid,
    output logic              ARready,
    input  logic [PROT_W-1:0] ARprot,
    output logic [DATA_W-1:0] Rdata,
    output logic              Rvalid,
    input  logic              RReady
);

    localparam int unsigned IW = MEM_WORDS_LOG2;

    wstate_e           w_q, w_d;
    rstate_e           r_q, r_d;
    logic [IW-1:0]     waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;

    logic [IW-1:0]     aw_idx, ar_idx;
    logic              ram_we, ram_re;
    logic [IW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [STRB_W-1:0] ram_wstrb;

    assign aw_idx = AWdata[IW+1:2];
    assign ar_idx = ARdata[IW+1:2];

    logic unused_ok;
    assign unused_ok = ^{AWprot, ARprot, AWdata[1:0], ARdata[1:0],
                         AWdata[ADDR_W-1:IW+2], ARdata[ADDR_W-1:IW+2]};

    always_comb begin
        w_d       = w_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ram_we    = 1'b0;
        ram_waddr = aw_idx;
        ram_wdata = Wdata;
        ram_wstrb = Wstrb;
        unique case (w_q)
            W_IDLE: begin
                if (AWvalid && Wvalid) begin
                    ram_we = 1'b1;
                    w_d    = W_RESP;
                end else if (AWvalid) begin
                    waddr_d = aw_idx;
                    w_d     = W_WAITD;
                end else if (Wvalid) begin
                    wdata_d = Wdata;
                    wstrb_d = Wstrb;
                    w_d     = W_WAITA;
                end
            end
            W_WAITD: begin
                ram_waddr = waddr_q;
                if (Wvalid) begin
                    ram_we = 1'b1;
                    w_d    = W_RESP;
                end
            end
            W_WAITA: begin
                ram_wdata = wdata_q;
                ram_wstrb = wstrb_q;
                if (AWvalid) begin
                    ram_we = 1'b1;
                    w_d    = W_RESP;
                end
            end
            W_RESP: begin
                if (Bready) begin
                    w_d = W_IDLE;
                end
            end
            default: w_d = W_IDLE;
        endcase
        // No commit may land while reset holds the FSM in idle.
        ram_we = ram_we && rstn;
    end

    always_comb begin
        r_d    = r_q;
        ram_re = 1'b0;
        unique case (r_q)
            R_IDLE: begin
                if (ARvalid) begin
                    ram_re = rstn;
                    r_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (RReady) begin
                    r_d = R_IDLE;
                end
            end
            default: r_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_q     <= W_IDLE;
            r_q     <= R_IDLE;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            w_q     <= w_d;
            r_q     <= r_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign AWready = rstn && (w_q == W_IDLE || w_q == W_WAITA);
    assign Wready  = rstn && (w_q == W_IDLE || w_q == W_WAITD);
    assign Bvalid  = rstn && (w_q == W_RESP);
    assign ARready = rstn && (r_q == R_IDLE);
    assign Rvalid  = rstn && (r_q == R_DATA);

    axil_ram_array #(
        .AW        (IW),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wstrb (ram_wstrb),
        .re    (ram_re),
        .raddr (ar_idx),
        .rdata (Rdata)
    );

endmodule

// File: tb/tb_axil_ram_slave.sv
// Directed scoreboard bench for axil_ram_slave.
// Reference RAM model predicts read data; queue holds pending reads.
module tb_axil_ram_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] AWdata, Wdata, ARdata;
    logic        AWvalid, Wvalid, ARvalid, Bready, RReady;
    logic [2:0]  AWprot, ARprot;
    logic [3:0]  Wstrb;
    logic        AWready, Wready, Bvalid, ARready, Rvalid;
    logic [31:0] Rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    axil_ram_slave #(.MEM_WORDS_LOG2(10), .INIT_ZERO(1'b0)) dut (
        .clk(clk), .rstn(rstn),
        .AWdata(AWdata), .AWvalid(AWvalid), .AWready(AWready), .AWprot(AWprot),
        .Wdata(Wdata), .Wstrb(Wstrb), .Wvalid(Wvalid), .Wready(Wready),
        .Bvalid(Bvalid), .Bready(Bready),
        .ARdata(ARdata), .ARvalid(ARvalid), .ARready(ARready), .ARprot(ARprot),
        .Rdata(Rdata), .Rvalid(Rvalid), .RReady(RReady)
    );

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        if (model.exists(widx(a))) return model[widx(a)];
        return 32'h0;
    endfunction

    function automatic void mwrite(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        logic [31:0] v;
        v = mread(a);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) v[8*i +: 8] = d[8*i +: 8];
        end
        model[widx(a)] = v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bresp(input string tag);
        chk({tag, "_bvalid"}, {31'b0, Bvalid}, 32'd1);
        Bready = 1'b1;
        tick();
        Bready = 1'b0;
        chk({tag, "_bdone"}, {29'b0, Bvalid, AWready, Wready}, 32'b011);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        chk({tag, "_rdy"}, {30'b0, AWready, Wready}, 32'b11);
        AWdata = a; AWvalid = 1'b1;
        Wdata = d; Wstrb = s; Wvalid = 1'b1;
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        mwrite(a, d, s);
        bresp(tag);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        logic [31:0] e;
        exp_q.push_back(mread(a));
        chk({tag, "_arready"}, {31'b0, ARready}, 32'd1);
        ARdata = a; ARvalid = 1'b1;
        tick();
        ARvalid = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, Rvalid}, 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_rdata"}, Rdata, e);
        RReady = 1'b1;
        tick();
        RReady = 1'b0;
        chk({tag, "_rdone"}, {30'b0, Rvalid, ARready}, 32'b01);
    endtask

    initial begin
        logic [31:0] e;
        rstn = 1'b0;
        AWdata = '0; Wdata = '0; ARdata = '0; Wstrb = '0;
        AWvalid = 0; Wvalid = 0; ARvalid = 0; Bready = 0; RReady = 0;
        AWprot = 3'b101; ARprot = 3'b010;
        tick(); tick();
        chk("reset_ctl", {27'b0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b0);
        chk("reset_rdata", Rdata, 32'h0);
        rstn = 1'b1;
        tick();
        chk("post_reset_rdy", {29'b0, AWready, Wready, ARready}, 32'b111);

        // Same-cycle AW/W write, then read back
        wr("w10", 32'h10, 32'hDEADBEEF, 4'hF);
        rd("r10", 32'h10);

        // W ahead of AW by two cycles
        Wdata = 32'h11223344; Wstrb = 4'hF; Wvalid = 1'b1;
        tick();
        Wvalid = 1'b0;
        chk("waita_1", {29'b0, AWready, Wready, Bvalid}, 32'b100);
        tick();
        chk("waita_2", {29'b0, AWready, Wready, Bvalid}, 32'b100);
        AWdata = 32'h20; AWvalid = 1'b1;
        tick();
        AWvalid = 1'b0;
        mwrite(32'h20, 32'h11223344, 4'hF);
        bresp("w20");
        rd("r20", 32'h20);

        // AW ahead of W
        AWdata = 32'h24; AWvalid = 1'b1;
        tick();
        AWvalid = 1'b0;
        chk("waitd", {29'b0, AWready, Wready, Bvalid}, 32'b010);
        Wdata = 32'hCAFEF00D; Wstrb = 4'hF; Wvalid = 1'b1;
        tick();
        Wvalid = 1'b0;
        mwrite(32'h24, 32'hCAFEF00D, 4'hF);
        bresp("w24");
        rd("r24", 32'h24);

        // Byte strobes
        wr("w30_pre", 32'h30, 32'hAABBCCDD, 4'hF);
        wr("w30_b0", 32'h30, 32'h00000055, 4'h1);
        chk("model_strb", mread(32'h30), 32'hAABBCC55);
        rd("r30_b0", 32'h30);
        wr("w30_s0", 32'h30, 32'hFFFFFFFF, 4'h0);
        rd("r30_s0", 32'h30);
        wr("w30_mid", 32'h30, 32'h12345678, 4'h6);
        rd("r30_mid", 32'h30);

        // Write-response backpressure
        AWdata = 32'h34; AWvalid = 1'b1;
        Wdata = 32'h0BADF00D; Wstrb = 4'hF; Wvalid = 1'b1;
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        mwrite(32'h34, 32'h0BADF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("bstall", {29'b0, Bvalid, AWready, Wready}, 32'b100);
            tick();
        end
        bresp("w34");

        // Read-data backpressure
        exp_q.push_back(mread(32'h34));
        ARdata = 32'h34; ARvalid = 1'b1;
        tick();
        ARvalid = 1'b0;
        ARdata = 32'h10;
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            chk("rstall_ctl", {30'b0, Rvalid, ARready}, 32'b10);
            chk("rstall_data", Rdata, e);
            tick();
        end
        RReady = 1'b1;
        tick();
        RReady = 1'b0;
        chk("rstall_done", {30'b0, Rvalid, ARready}, 32'b01);

        // Address wrap modulo depth
        wr("w1000", 32'h1000, 32'h5A5A5A5A, 4'hF);
        rd("r0_wrap", 32'h0);
        rd("r1004_wrap", 32'h1004);

        // Read and write committing to the same word on one edge
        wr("w40", 32'h40, 32'h01010101, 4'hF);
        exp_q.push_back(mread(32'h40));
        AWdata = 32'h40; AWvalid = 1'b1;
        Wdata = 32'h02020202; Wstrb = 4'hF; Wvalid = 1'b1;
        ARdata = 32'h40; ARvalid = 1'b1;
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0; ARvalid = 1'b0;
        mwrite(32'h40, 32'h02020202, 4'hF);
        chk("coll_rvalid", {31'b0, Rvalid}, 32'd1);
        e = exp_q.pop_front();
        chk("coll_old", Rdata, e);
        RReady = 1'b1;
        bresp("wcoll");
        RReady = 1'b0;
        rd("r40_new", 32'h40);

        // Reset during W_WAITD must drop the write
        wr("w50", 32'h50, 32'h12345678, 4'hF);
        AWdata = 32'h50; AWvalid = 1'b1;
        tick();
        AWvalid = 1'b0;
        chk("rst_waitd_pre", {30'b0, AWready, Wready}, 32'b01);
        Wdata = 32'hFFFFFFFF; Wstrb = 4'hF; Wvalid = 1'b1;
        rstn = 1'b0;
        #1;
        chk("rst_waitd_ctl", {27'b0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b0);
        tick();
        Wvalid = 1'b0;
        rstn = 1'b1;
        tick();
        chk("rst_waitd_rdy", {29'b0, AWready, Wready, ARready}, 32'b111);
        rd("r50_kept", 32'h50);

        // Reset during R_DATA
        ARdata = 32'h10; ARvalid = 1'b1;
        tick();
        ARvalid = 1'b0;
        chk("rst_rdata_pre", {31'b0, Rvalid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_rdata_ctl", {27'b0, AWready, Wready, ARready, Bvalid, Rvalid}, 32'b0);
        chk("rst_rdata_zero", Rdata, 32'h0);
        tick();
        rstn = 1'b1;
        tick();
        rd("r10_after", 32'h10);
        wr("w60_after", 32'h60, 32'h600DCAFE, 4'hF);
        rd("r60_after", 32'h60);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
